// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: pause levels, controller FSM state
// encoding, the zero word and a small register-match helper.
// Used by pipe_ctrl, hazard_detect, and the if_id / id_ex stages.
package pipe_ctrl_pkg;

  // A stage freezes when pause_flag >= its level.
  localparam logic [2:0] Pause_None = 3'd0;
  localparam logic [2:0] Pause_Pc   = 3'd1;  // freeze pc
  localparam logic [2:0] Pause_If   = 3'd2;  // also hold if_id
  localparam logic [2:0] Pause_Id   = 3'd3;  // also bubble id_ex

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef logic [4:0] reg_idx_t;

  // True when an enabled source read hits the given destination.
  function automatic logic src_hit(logic re, reg_idx_t rs, reg_idx_t rd);
    return re && (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bus between the controller and the pipeline stages.
//   slave  : controller side (pipe_ctrl) - takes EX/ID/bus status, drives
//            pause level, redirect, stall count and watchdog flag.
//   master : pipeline side - the mirror image.
interface pipe_ctrl_if;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        hold_ex_i;
  logic        hold_bus_i;
  logic        ex_is_load_i;
  logic [4:0]  ex_rd_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        id_rs1_re_i;
  logic        id_rs2_re_i;
  logic [2:0]  pause_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic [31:0] stall_cnt_o;
  logic        hold_timeout_o;

  modport slave (
    input  jump_flag_i, jump_addr_i, hold_ex_i, hold_bus_i, ex_is_load_i,
           ex_rd_i, id_rs1_i, id_rs2_i, id_rs1_re_i, id_rs2_re_i,
    output pause_flag_o, jump_flag_o, jump_addr_o, stall_cnt_o, hold_timeout_o
  );

  modport master (
    output jump_flag_i, jump_addr_i, hold_ex_i, hold_bus_i, ex_is_load_i,
           ex_rd_i, id_rs1_i, id_rs2_i, id_rs1_re_i, id_rs2_re_i,
    input  pause_flag_o, jump_flag_o, jump_addr_o, stall_cnt_o, hold_timeout_o
  );
endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: purely combinational load-use detector.
//   ex_is_load_i, ex_rd_i        : instruction in EX
//   id_rs*_i, id_rs*_re_i        : sources of the instruction in ID
//   hazard_o                     : ID needs a loaded value not yet available
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic     ex_is_load_i,
  input  reg_idx_t ex_rd_i,
  input  reg_idx_t id_rs1_i,
  input  reg_idx_t id_rs2_i,
  input  logic     id_rs1_re_i,
  input  logic     id_rs2_re_i,
  output logic     hazard_o
);
  // x0 never carries a real dependency.
  assign hazard_o = ex_is_load_i && (ex_rd_i != 5'd0) &&
                    (src_hit(id_rs1_re_i, id_rs1_i, ex_rd_i) ||
                     src_hit(id_rs2_re_i, id_rs2_i, ex_rd_i));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline pause / redirect controller.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pipe_ctrl_if.slave - hazard/hold/jump inputs, pause level,
//                redirect, stall-cycle counter and sticky hold watchdog.
// Redirect and pause are combinational (zero latency); the FSM only
// remembers that a flush bubble or a hold is in progress.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input logic       clk,
  input logic       rst_n,
  pipe_ctrl_if.slave bus
);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

  logic [1:0]     state_q, state_d;
  logic [31:0]    stall_q, stall_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           timeout_q, timeout_d;
  logic           hazard;
  logic [2:0]     pause;
  logic           jf;
  logic [31:0]    ja;

  hazard_detect u_hazard (
    .ex_is_load_i (bus.ex_is_load_i),
    .ex_rd_i      (bus.ex_rd_i),
    .id_rs1_i     (bus.id_rs1_i),
    .id_rs2_i     (bus.id_rs2_i),
    .id_rs1_re_i  (bus.id_rs1_re_i),
    .id_rs2_re_i  (bus.id_rs2_re_i),
    .hazard_o     (hazard)
  );

  // Priority: jump > hold_ex > hold_bus > load-use > flush bubble.
  // Every state has the same exits, so the next state depends only on
  // the inputs: jump -> FLUSH, any hold -> HOLD, else RUN. A load-use
  // stall is a one-cycle bubble and never moves the FSM.
  always_comb begin
    pause   = Pause_None;
    jf      = 1'b0;
    ja      = ZeroWord;
    state_d = ST_RUN;
    if (!rst_n) begin
      state_d = ST_RUN;   // outputs quiet during reset regardless of inputs
    end else if (bus.jump_flag_i) begin
      jf      = 1'b1;
      ja      = bus.jump_addr_i;
      pause   = Pause_Id;
      state_d = ST_FLUSH;
    end else if (bus.hold_ex_i) begin
      pause   = Pause_Id;
      state_d = ST_HOLD;
    end else if (bus.hold_bus_i) begin
      pause   = Pause_Pc;
      state_d = ST_HOLD;
    end else if (hazard) begin
      pause   = Pause_Id;
    end else if (state_q == ST_FLUSH) begin
      pause   = Pause_Id;   // kill the wrong-path instruction in ID
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (pause != Pause_None && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
    // Counts cycles spent in HOLD; any other state restarts it.
    wd_d = '0;
    if (state_q == ST_HOLD) wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + WDW'(1);
    timeout_d = timeout_q | (wd_d == WD_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      stall_q   <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stall_q   <= stall_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.pause_flag_o   = pause;
  assign bus.jump_flag_o    = jf;
  assign bus.jump_addr_o    = ja;
  assign bus.stall_cnt_o    = stall_q;
  assign bus.hold_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        jf;
    logic [31:0] ja;
    logic        hex, hbus, ld;
    logic [4:0]  rd, rs1, rs2;
    logic        re1, re2;
    logic [2:0]  e_pause;
    logic        e_jf;
    logic [31:0] e_ja;
    logic [1:0]  e_st;
  } vec_t;

  function automatic vec_t mk(logic jf, logic [31:0] ja, logic hex, logic hbus,
                              logic ld, logic [4:0] rd, logic [4:0] rs1,
                              logic [4:0] rs2, logic re1, logic re2,
                              logic [2:0] ep, logic ejf, logic [31:0] eja,
                              logic [1:0] est);
    vec_t v;
    v.jf = jf; v.ja = ja; v.hex = hex; v.hbus = hbus; v.ld = ld;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.re1 = re1; v.re2 = re2;
    v.e_pause = ep; v.e_jf = ejf; v.e_ja = eja; v.e_st = est;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.jump_flag_i  = 1'b0; bus.jump_addr_i = 32'h0;
    bus.hold_ex_i    = 1'b0; bus.hold_bus_i  = 1'b0;
    bus.ex_is_load_i = 1'b0; bus.ex_rd_i     = 5'd0;
    bus.id_rs1_i     = 5'd0; bus.id_rs2_i    = 5'd0;
    bus.id_rs1_re_i  = 1'b0; bus.id_rs2_re_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  vec_t vt[13];

  initial begin
    // Vectors applied from RUN: combinational outputs, then next state.
    //            jf  addr          hex  hbus ld  rd  rs1 rs2 re1 re2  pause jf  addr          state
    vt[0]  = mk(0, 32'h0,          0,   0,   0,  0,  0,  0,  0,  0,   3'd0, 0, 32'h0,          ST_RUN);
    vt[1]  = mk(1, 32'h100,        0,   0,   0,  0,  0,  0,  0,  0,   3'd3, 1, 32'h100,        ST_FLUSH);
    vt[2]  = mk(0, 32'h0,          1,   0,   0,  0,  0,  0,  0,  0,   3'd3, 0, 32'h0,          ST_HOLD);
    vt[3]  = mk(0, 32'h0,          0,   1,   0,  0,  0,  0,  0,  0,   3'd1, 0, 32'h0,          ST_HOLD);
    vt[4]  = mk(0, 32'h0,          0,   0,   1,  5,  0,  5,  0,  1,   3'd3, 0, 32'h0,          ST_RUN);
    vt[5]  = mk(0, 32'h0,          0,   0,   1,  0,  0,  0,  0,  1,   3'd0, 0, 32'h0,          ST_RUN);
    vt[6]  = mk(0, 32'h0,          0,   0,   1,  7,  7,  3,  1,  0,   3'd3, 0, 32'h0,          ST_RUN);
    vt[7]  = mk(0, 32'h0,          0,   0,   1,  7,  7,  3,  0,  1,   3'd0, 0, 32'h0,          ST_RUN);
    vt[8]  = mk(0, 32'h0,          0,   0,   0,  9,  9,  9,  1,  1,   3'd0, 0, 32'h0,          ST_RUN);
    vt[9]  = mk(1, 32'h200,        1,   0,   0,  0,  0,  0,  0,  0,   3'd3, 1, 32'h200,        ST_FLUSH);
    vt[10] = mk(0, 32'h0,          0,   1,   1,  4,  4,  0,  1,  0,   3'd1, 0, 32'h0,          ST_HOLD);
    vt[11] = mk(0, 32'h0,          1,   1,   0,  0,  0,  0,  0,  0,   3'd3, 0, 32'h0,          ST_HOLD);
    vt[12] = mk(1, 32'hDEADBEEF,   0,   1,   1,  6,  6,  6,  1,  1,   3'd3, 1, 32'hDEADBEEF,   ST_FLUSH);

    // Reset: outputs quiet even with active inputs.
    rst_n = 1'b0;
    idle();
    bus.jump_flag_i = 1'b1; bus.jump_addr_i = 32'h1234; bus.hold_ex_i = 1'b1;
    #3;
    chk("rst_pause", 32'(bus.pause_flag_o), 32'd0);
    chk("rst_jflag", 32'(bus.jump_flag_o), 32'd0);
    chk("rst_jaddr", bus.jump_addr_o, 32'd0);
    tick(); tick();
    chk("rst_stall", bus.stall_cnt_o, 32'd0);
    chk("rst_tmo",   32'(bus.hold_timeout_o), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_RUN));
    idle();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      bus.jump_flag_i = vt[i].jf;  bus.jump_addr_i = vt[i].ja;
      bus.hold_ex_i   = vt[i].hex; bus.hold_bus_i  = vt[i].hbus;
      bus.ex_is_load_i = vt[i].ld; bus.ex_rd_i = vt[i].rd;
      bus.id_rs1_i = vt[i].rs1; bus.id_rs2_i = vt[i].rs2;
      bus.id_rs1_re_i = vt[i].re1; bus.id_rs2_re_i = vt[i].re2;
      #1;
      chk($sformatf("v%0d_pause", i), 32'(bus.pause_flag_o), 32'(vt[i].e_pause));
      chk($sformatf("v%0d_jflag", i), 32'(bus.jump_flag_o), 32'(vt[i].e_jf));
      chk($sformatf("v%0d_jaddr", i), bus.jump_addr_o, vt[i].e_ja);
      tick();
      chk($sformatf("v%0d_state", i), 32'(dut.state_q), 32'(vt[i].e_st));
      idle();
      #1;
      chk($sformatf("v%0d_after", i), 32'(bus.pause_flag_o),
          (vt[i].e_st == ST_FLUSH) ? 32'd3 : 32'd0);
      tick();
      chk($sformatf("v%0d_back", i), 32'(dut.state_q), 32'(ST_RUN));
    end

    // Jump: redirect + two bubble cycles, then free.
    pulse_rst();
    bus.jump_flag_i = 1'b1; bus.jump_addr_i = 32'h100;
    #1;
    chk("jmp_flag", 32'(bus.jump_flag_o), 32'd1);
    chk("jmp_addr", bus.jump_addr_o, 32'h100);
    chk("jmp_p0",   32'(bus.pause_flag_o), 32'd3);
    tick(); idle(); #1;
    chk("jmp_p1", 32'(bus.pause_flag_o), 32'd3);
    tick();
    chk("jmp_p2",    32'(bus.pause_flag_o), 32'd0);
    chk("jmp_stall", bus.stall_cnt_o, 32'd2);

    // Hold from EX for 4 cycles, then bus hold for 2.
    pulse_rst();
    bus.hold_ex_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("hex_p%0d", k), 32'(bus.pause_flag_o), 32'd3);
      tick();
      chk($sformatf("hex_s%0d", k), 32'(dut.state_q), 32'(ST_HOLD));
    end
    idle(); #1;
    chk("hex_rel", 32'(bus.pause_flag_o), 32'd0);
    tick();
    chk("hex_run",   32'(dut.state_q), 32'(ST_RUN));
    chk("hex_stall", bus.stall_cnt_o, 32'd4);
    bus.hold_bus_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("hbus_p%0d", k), 32'(bus.pause_flag_o), 32'd1);
      tick();
    end
    idle(); tick();
    chk("hbus_stall", bus.stall_cnt_o, 32'd6);
    chk("hbus_run",   32'(dut.state_q), 32'(ST_RUN));

    // Jump together with hold: jump wins, hold serviced from FLUSH.
    bus.jump_flag_i = 1'b1; bus.jump_addr_i = 32'h400; bus.hold_ex_i = 1'b1;
    #1;
    chk("sim_jflag", 32'(bus.jump_flag_o), 32'd1);
    tick();
    chk("sim_flush", 32'(dut.state_q), 32'(ST_FLUSH));
    bus.jump_flag_i = 1'b0; bus.jump_addr_i = 32'h0;
    #1;
    chk("sim_pause", 32'(bus.pause_flag_o), 32'd3);
    chk("sim_jf0",   32'(bus.jump_flag_o), 32'd0);
    tick();
    chk("sim_hold",  32'(dut.state_q), 32'(ST_HOLD));
    idle(); tick();

    // Watchdog: HOLD entered at the first edge, the 8th HOLD cycle ends at edge 9.
    pulse_rst();
    bus.hold_bus_i = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk($sformatf("wd_e%0d", c), 32'(bus.hold_timeout_o), (c >= 9) ? 32'd1 : 32'd0);
    end
    idle(); tick();
    chk("wd_sticky1", 32'(bus.hold_timeout_o), 32'd1);
    chk("wd_run",     32'(dut.state_q), 32'(ST_RUN));
    tick();
    chk("wd_sticky2", 32'(bus.hold_timeout_o), 32'd1);

    // Reset mid-hold.
    bus.hold_ex_i = 1'b1;
    tick();
    chk("mh_hold", 32'(dut.state_q), 32'(ST_HOLD));
    rst_n = 1'b0;
    #1;
    chk("mh_pause", 32'(bus.pause_flag_o), 32'd0);
    chk("mh_state", 32'(dut.state_q), 32'(ST_RUN));
    chk("mh_stall", bus.stall_cnt_o, 32'd0);
    chk("mh_tmo",   32'(bus.hold_timeout_o), 32'd0);
    chk("mh_wd",    32'(dut.wd_q), 32'd0);
    idle();
    rst_n = 1'b1;
    #1;
    chk("mh_rel", 32'(bus.pause_flag_o), 32'd0);
    tick();
    chk("mh_run", 32'(dut.state_q), 32'(ST_RUN));

    // Reset mid-flush: no leftover bubble after release.
    bus.jump_flag_i = 1'b1; bus.jump_addr_i = 32'h80;
    tick();
    chk("mf_flush", 32'(dut.state_q), 32'(ST_FLUSH));
    idle();
    rst_n = 1'b0;
    #1;
    chk("mf_pause", 32'(bus.pause_flag_o), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mf_rel", 32'(bus.pause_flag_o), 32'd0);
    tick();
    chk("mf_run",   32'(dut.state_q), 32'(ST_RUN));
    chk("mf_stall", bus.stall_cnt_o, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 1024, is the number of consecutive HOLD cycles after which the watchdog fires.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 jump_flag_i  input  1  EX resolved a taken branch or jump this cycle.
REQ-005 jump_addr_i  input  32  target address of the jump.
REQ-006 hold_ex_i  input  1  EX multi-cycle operation busy.
REQ-007 hold_bus_i  input  1  instruction bus not granted or fetch pending.
REQ-008 ex_is_load_i  input  1  instruction in EX is a load.
REQ-009 ex_rd_i  input  5  destination register of the instruction in EX.
REQ-010 id_rs1_i, id_rs2_i  input  5 each  source registers of the instruction in ID.
REQ-011 id_rs1_re_i, id_rs2_re_i  input  1 each  source-register read enables.
REQ-012 pause_flag_o  output  3  pipeline pause level to pc, if_id and id_ex.
REQ-013 jump_flag_o  output  1  redirect request to pc.
REQ-014 jump_addr_o  output  32  redirect target.
REQ-015 stall_cnt_o  output  32  count of cycles with pause_flag_o != Pause_None.
REQ-016 hold_timeout_o  output  1  sticky watchdog flag.

Function
REQ-017 The pause encoding SHALL be Pause_None=0, Pause_Pc=1 (freeze pc), Pause_If=2 (also hold if_id), Pause_Id=3 (also bubble id_ex); a stage is affected when pause_flag_o >= its level.
REQ-018 jump_flag_o, jump_addr_o and pause_flag_o SHALL be combinational from inputs and state, with zero latency.
REQ-019 Load-use hazard SHALL be ex_is_load_i & ex_rd_i!=0 & ((id_rs1_re_i & id_rs1_i==ex_rd_i) | (id_rs2_re_i & id_rs2_i==ex_rd_i)).
REQ-020 Priority SHALL be jump > hold_ex > hold_bus > load-use > FLUSH state > none.
REQ-021 When jump_flag_i=1, the outputs SHALL be jump_flag_o=1, jump_addr_o=jump_addr_i and pause_flag_o=Pause_Id, and the next state SHALL be FLUSH.
REQ-022 When jump_flag_i=0, jump_flag_o SHALL be 0 and jump_addr_o SHALL be 0.
REQ-023 hold_ex_i=1 SHALL give pause_flag_o=Pause_Id.
REQ-024 hold_bus_i=1 SHALL give pause_flag_o=Pause_Pc.
REQ-025 A load-use hazard SHALL give pause_flag_o=Pause_Id for exactly the cycle the hazard is present.
REQ-026 The FSM SHALL have the states RUN, HOLD and FLUSH.
REQ-027 RUN SHALL go to FLUSH on a jump, go to HOLD on hold_ex_i|hold_bus_i, and otherwise stay in RUN.
REQ-028 HOLD SHALL go to FLUSH on a jump, stay in HOLD while a hold is asserted, and otherwise go to RUN.
REQ-029 FLUSH SHALL drive pause_flag_o=Pause_Id for one cycle unless overridden per REQ-020, then go to FLUSH on a new jump, to HOLD on a hold, and otherwise to RUN.
REQ-030 A load-use hazard alone SHALL NOT change state.
REQ-031 stall_cnt_o SHALL increment by 1 each cycle pause_flag_o != Pause_None and SHALL saturate at 32'hFFFF_FFFF.
REQ-032 The watchdog counter SHALL count consecutive cycles in HOLD, clear on leaving HOLD, and saturate at TIMEOUT.
REQ-033 hold_timeout_o SHALL set on the cycle the watchdog count reaches TIMEOUT and stay set until reset.
REQ-034 A jump arriving in the same cycle as a hold SHALL win, and the hold SHALL be serviced from FLUSH on the next cycle.

Reset
REQ-035 While rst_n=0, the block SHALL hold state=RUN, stall_cnt_o=0, watchdog count=0 and hold_timeout_o=0.
REQ-036 In reset, the combinational outputs SHALL be pause_flag_o=Pause_None, jump_flag_o=0 and jump_addr_o=0, regardless of inputs.
REQ-037 Assertion of reset mid-hold or mid-flush SHALL abort that operation immediately, with no pending flush after release.

Structure
REQ-038 The Pause_* encodings, the FSM state encoding and ZeroWord SHALL live in the shared defines file, which id_ex and if_id already use.
REQ-039 The hazard detector SHALL be a combinational sub-module named hazard_detect; all sequential logic SHALL stay in pipe_ctrl.

Verification
REQ-040 Jump: jump_flag_i=1, jump_addr_i=0x0000_0100 for 1 cycle -> jump_flag_o=1, addr 0x100, pause=3 that cycle; pause=3 the next cycle; then pause=0; stall_cnt_o=2.
REQ-041 Load-use: ex_is_load_i=1, ex_rd_i=5, id_rs2_i=5, id_rs2_re_i=1 for 1 cycle -> pause=3 for 1 cycle, state stays RUN; the same stimulus with ex_rd_i=0 -> pause=0.
REQ-042 Hold: hold_ex_i=1 for 4 cycles -> pause=3 for 4 cycles, HOLD then RUN; hold_bus_i alone for 2 cycles -> pause=1 for 2 cycles.
REQ-043 Simultaneous: jump_flag_i=1 and hold_ex_i=1 in the same cycle -> jump_flag_o=1; next cycle with hold_ex_i still 1 -> pause=3, state HOLD.
REQ-044 Watchdog: TIMEOUT=8, hold_bus_i=1 for 10 cycles -> hold_timeout_o rises after the 8th HOLD cycle and stays 1 after the hold drops; rst_n pulse -> all outputs and counters return to 0.
